algo_1r1w_refr_sched: RTL and testbench

Refresh scheduler for the DRAM-backed T1 bank array of the 1R1W algorithmic memory. It generates one refresh credit every REFFREQ cycles and issues each credit to the next refresh bank in round-robin order. A refresh is placed only in a cycle where it does not collide with the read or write access launching that cycle. When credits back up to MAXPEND, it stalls the core so a refresh can be forced. It sits between the core's access pipeline and the t1_refrC/t1_bankC memory port.

---
 rtl/algo_1r1w_refr_sched_pkg.sv | 10 +
 rtl/algo_1r1w_refr_sched.sv | 116 +++++++++++
 tb/tb_algo_1r1w_refr_sched.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/algo_1r1w_refr_sched_pkg.sv
// algo_1r1w_refr_sched_pkg: scheduler state encoding and parameter legality check
package algo_1r1w_refr_sched_pkg;

    typedef enum logic {INIT, RUN} state_t;

    function automatic bit params_ok(int reffreq, int maxpend, int bitpend);
        return reffreq >= 2 && maxpend >= 1 && bitpend >= $clog2(maxpend + 1);
    endfunction

endpackage

// File: rtl/algo_1r1w_refr_sched.sv
// algo_1r1w_refr_sched: round-robin T1 refresh scheduler with credit counter and forced-refresh stall
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   nxt_rd, nxt_rd_bank      read launching next cycle and its refresh bank
//   nxt_wr, nxt_wr_bank      write launching next cycle and its refresh bank
//   t1_refrC, t1_bankC       registered refresh command and bank
//   stall                    core must drop its nxt_* accesses this cycle
//   ready                    initial refresh sweep complete
//   pend_cnt                 outstanding refresh credits
//   err_ovf                  sticky: a credit was dropped at saturation
module algo_1r1w_refr_sched
    import algo_1r1w_refr_sched_pkg::*;
#(
    parameter int NUMRBNK = 4,
    parameter int BITRBNK = 2,
    parameter int REFFREQ = 6,
    parameter int MAXPEND = 4,
    parameter int BITPEND = 3,
    parameter int REFRESH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               nxt_rd,
    input  logic [BITRBNK-1:0] nxt_rd_bank,
    input  logic               nxt_wr,
    input  logic [BITRBNK-1:0] nxt_wr_bank,
    output logic               t1_refrC,
    output logic [BITRBNK-1:0] t1_bankC,
    output logic               stall,
    output logic               ready,
    output logic [BITPEND-1:0] pend_cnt,
    output logic               err_ovf
);

    localparam int BITTIME = $clog2(REFFREQ);

    if (!params_ok(REFFREQ, MAXPEND, BITPEND)) begin : g_bad_params
        $error("algo_1r1w_refr_sched: illegal REFFREQ/MAXPEND/BITPEND");
    end

    state_t             state, state_n;
    logic [BITRBNK-1:0] rr_ptr, ptr_n, ptr_inc, bank_n;
    logic [BITTIME-1:0] timer, timer_n;
    logic [BITPEND-1:0] pend_n;
    logic               ovf_n, refr_n, ready_n, wrap, conflict, issue;

    always_comb begin
        ptr_inc  = rr_ptr == BITRBNK'(NUMRBNK - 1) ? '0 : rr_ptr + 1'b1;
        wrap     = REFRESH != 0 && state == RUN && timer == BITTIME'(REFFREQ - 1);
        conflict = (nxt_rd && nxt_rd_bank == rr_ptr) || (nxt_wr && nxt_wr_bank == rr_ptr);
        stall    = REFRESH != 0 && state == RUN && pend_cnt == BITPEND'(MAXPEND);
        // a stalled core launches nothing next cycle, so the refresh can be forced
        issue    = state == RUN && pend_cnt != '0 && (!conflict || stall);
        state_n  = state;
        ptr_n    = rr_ptr;
        timer_n  = timer;
        pend_n   = pend_cnt;
        ovf_n    = err_ovf;
        refr_n   = 1'b0;
        bank_n   = t1_bankC;
        ready_n  = ready;
        if (state == INIT) begin
            if (REFRESH == 0) begin
                state_n = RUN;
                ready_n = 1'b1;
            end else begin
                refr_n = 1'b1;
                bank_n = rr_ptr;
                ptr_n  = ptr_inc;
                if (rr_ptr == BITRBNK'(NUMRBNK - 1)) begin
                    state_n = RUN;
                    ready_n = 1'b1;
                end
            end
        end else begin
            if (REFRESH != 0)
                timer_n = wrap ? '0 : timer + 1'b1;
            if (issue) begin
                refr_n = 1'b1;
                bank_n = rr_ptr;
                ptr_n  = ptr_inc;
            end
            // a credit arriving in the same cycle as an issue cancels out
            if (issue && !wrap)
                pend_n = pend_cnt - 1'b1;
            else if (wrap && !issue) begin
                if (stall)
                    ovf_n = 1'b1;
                else
                    pend_n = pend_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            rr_ptr   <= '0;
            timer    <= '0;
            pend_cnt <= '0;
            err_ovf  <= 1'b0;
            t1_refrC <= 1'b0;
            t1_bankC <= '0;
            ready    <= 1'b0;
        end else begin
            state    <= state_n;
            rr_ptr   <= ptr_n;
            timer    <= timer_n;
            pend_cnt <= pend_n;
            err_ovf  <= ovf_n;
            t1_refrC <= refr_n;
            t1_bankC <= bank_n;
            ready    <= ready_n;
        end
    end

endmodule

// File: tb/tb_algo_1r1w_refr_sched.sv
// tb_algo_1r1w_refr_sched: table-driven and scoreboard bench for the refresh scheduler
module tb_algo_1r1w_refr_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       nxt_rd = 1'b0, nxt_wr = 1'b0;
    logic [1:0] nxt_rd_bank = '0, nxt_wr_bank = '0;
    logic       t1_refrC, stall, ready, err_ovf;
    logic [1:0] t1_bankC;
    logic [2:0] pend_cnt;
    logic       off_refr, off_stall, off_ready, off_ovf;
    logic [1:0] off_bank;
    logic [2:0] off_pend;

    always #5 clk = ~clk;

    algo_1r1w_refr_sched u_on (
        .clk(clk), .rst(rst),
        .nxt_rd(nxt_rd), .nxt_rd_bank(nxt_rd_bank),
        .nxt_wr(nxt_wr), .nxt_wr_bank(nxt_wr_bank),
        .t1_refrC(t1_refrC), .t1_bankC(t1_bankC), .stall(stall),
        .ready(ready), .pend_cnt(pend_cnt), .err_ovf(err_ovf)
    );

    algo_1r1w_refr_sched #(.REFRESH(0)) u_off (
        .clk(clk), .rst(rst),
        .nxt_rd(nxt_rd), .nxt_rd_bank(nxt_rd_bank),
        .nxt_wr(nxt_wr), .nxt_wr_bank(nxt_wr_bank),
        .t1_refrC(off_refr), .t1_bankC(off_bank), .stall(off_stall),
        .ready(off_ready), .pend_cnt(off_pend), .err_ovf(off_ovf)
    );

    typedef struct {
        logic refr;
        int   bank;
        int   pend;
        logic stall;
        logic ready;
        logic ovf;
        logic off_ready;
    } exp_t;

    typedef struct {
        int mode;
        int n;
        int refr;
        int bank;
        int pend;
        int stall;
        int ready;
        int ovf;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[0:18];
    int   vecs = 0, errs = 0, cyc = 0;

    bit m_init, m_refr, m_ready, m_ovf, m_off_ready;
    int m_ptr, m_timer, m_pend, m_bank;

    task automatic cmp(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_init = 1; m_refr = 0; m_ready = 0; m_ovf = 0; m_off_ready = 0;
        m_ptr = 0; m_timer = 0; m_pend = 0; m_bank = 0;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.refr = m_refr; e.bank = m_bank; e.pend = m_pend;
        e.stall = !m_init && m_pend == 4;
        e.ready = m_ready; e.ovf = m_ovf; e.off_ready = m_off_ready;
        return e;
    endfunction

    task automatic model_step(input logic rd, input int rb, input logic wr, input int wb);
        bit full, conf, go, wrp;
        m_off_ready = 1;
        if (m_init) begin
            m_refr = 1;
            m_bank = m_ptr;
            if (m_ptr == 3) begin
                m_init = 0; m_ready = 1; m_ptr = 0;
            end else
                m_ptr++;
        end else begin
            full = m_pend == 4;
            conf = (rd && rb == m_ptr) || (wr && wb == m_ptr);
            go   = m_pend > 0 && (!conf || full);
            wrp  = m_timer == 5;
            m_refr = go;
            if (go) begin
                m_bank = m_ptr;
                m_ptr = (m_ptr + 1) % 4;
            end
            m_pend = m_pend - int'(go) + int'(wrp);
            if (m_pend > 4) begin
                m_pend = 4;
                m_ovf = 1;
            end
            m_timer = (m_timer + 1) % 6;
        end
    endtask

    task automatic tick(input logic rd, input int rb, input logic wr, input int wb);
        exp_t e;
        if (sbq.size() == 0) begin
            vecs++; errs++;
            $display("FAIL scoreboard cycle %0d: no expectation queued", cyc);
        end else begin
            e = sbq.pop_front();
            cmp("refrC", int'(t1_refrC), int'(e.refr));
            if (e.refr) cmp("bankC", int'(t1_bankC), e.bank);
            cmp("pend_cnt", int'(pend_cnt), e.pend);
            cmp("stall", int'(stall), int'(e.stall));
            cmp("ready", int'(ready), int'(e.ready));
            cmp("err_ovf", int'(err_ovf), int'(e.ovf));
            cmp("off_refrC", int'(off_refr), 0);
            cmp("off_stall", int'(off_stall), 0);
            cmp("off_ovf", int'(off_ovf), 0);
            cmp("off_pend", int'(off_pend), 0);
            cmp("off_bank", int'(off_bank), 0);
            cmp("off_ready", int'(off_ready), int'(e.off_ready));
        end
        nxt_rd = rd; nxt_rd_bank = 2'(rb);
        nxt_wr = wr; nxt_wr_bank = 2'(wb);
        model_step(rd, rb, wr, wb);
        sbq.push_back(model_out());
        @(negedge clk);
        cyc++;
    endtask

    // 0 idle, 1 read conflict honouring stall, 2 read conflict ignoring stall,
    // 3 random traffic honouring stall, 4 write conflict honouring stall
    task automatic drive(input int mode);
        logic r, w;
        case (mode)
            1: tick(!stall, m_ptr, 1'b0, 0);
            2: tick(1'b1, m_ptr, 1'b0, 0);
            3: begin
                r = 1'($urandom_range(0, 1)) && !stall;
                w = 1'($urandom_range(0, 1)) && !stall;
                tick(r, int'($urandom_range(0, 3)), w, int'($urandom_range(0, 3)));
            end
            4: tick(1'b0, 0, !stall, m_ptr);
            default: tick(1'b0, 0, 1'b0, 0);
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nxt_rd = 1'b0; nxt_wr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        sbq.delete();
        sbq.push_back(model_out());
        cyc = 0;
    endtask

    task automatic check_reset_vals();
        cmp("rst_refrC", int'(t1_refrC), 0);
        cmp("rst_bankC", int'(t1_bankC), 0);
        cmp("rst_stall", int'(stall), 0);
        cmp("rst_ready", int'(ready), 0);
        cmp("rst_pend", int'(pend_cnt), 0);
        cmp("rst_ovf", int'(err_ovf), 0);
        cmp("rst_off_ready", int'(off_ready), 0);
    endtask

    initial begin
        int guard;
        tbl[0]  = '{0, 1,  1, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 3,  1, 3, 0, 0, 1, 0};
        tbl[2]  = '{0, 6,  0, -1, 1, 0, 1, 0};
        tbl[3]  = '{0, 1,  1, 0, 0, 0, 1, 0};
        tbl[4]  = '{0, 6,  1, 1, 0, 0, 1, 0};
        tbl[5]  = '{1, 23, 0, -1, 4, 1, 1, 0};
        tbl[6]  = '{1, 1,  1, 2, 3, 0, 1, 0};
        tbl[7]  = '{1, 5,  0, -1, 4, 1, 1, 0};
        tbl[8]  = '{1, 1,  1, 3, 3, 0, 1, 0};
        tbl[9]  = '{0, 1,  1, 0, 2, 0, 1, 0};
        tbl[10] = '{1, 3,  0, -1, 2, 0, 1, 0};
        tbl[11] = '{0, 1,  1, 1, 2, 0, 1, 0};
        tbl[12] = '{0, 1,  1, 2, 1, 0, 1, 0};
        tbl[13] = '{0, 1,  1, 3, 0, 0, 1, 0};
        tbl[14] = '{2, 22, 0, -1, 4, 1, 1, 0};
        tbl[15] = '{2, 1,  1, 0, 3, 0, 1, 0};
        tbl[16] = '{2, 30, -1, -1, -1, -1, 1, 0};
        tbl[17] = '{3, 300, -1, -1, -1, -1, 1, 0};
        tbl[18] = '{4, 60, -1, -1, -1, -1, 1, 0};

        @(negedge clk);
        do_reset();
        check_reset_vals();
        for (int i = 0; i <= 18; i++) begin
            repeat (tbl[i].n) drive(tbl[i].mode);
            if (tbl[i].refr >= 0) cmp($sformatf("row%0d_refrC", i), int'(t1_refrC), tbl[i].refr);
            if (tbl[i].bank >= 0) cmp($sformatf("row%0d_bankC", i), int'(t1_bankC), tbl[i].bank);
            if (tbl[i].pend >= 0) cmp($sformatf("row%0d_pend", i), int'(pend_cnt), tbl[i].pend);
            if (tbl[i].stall >= 0) cmp($sformatf("row%0d_stall", i), int'(stall), tbl[i].stall);
            cmp($sformatf("row%0d_ready", i), int'(ready), tbl[i].ready);
            cmp($sformatf("row%0d_ovf", i), int'(err_ovf), tbl[i].ovf);
        end

        do_reset();
        check_reset_vals();
        for (int i = 0; i < 4; i++) begin
            drive(0);
            cmp("sweep_refrC", int'(t1_refrC), 1);
            cmp("sweep_bankC", int'(t1_bankC), i);
            cmp("sweep_ready", int'(ready), i == 3 ? 1 : 0);
            if (i == 0) cmp("off_ready_c1", int'(off_ready), 1);
        end
        guard = 0;
        while (m_ptr != 2 && guard < 100) begin
            drive(0);
            guard++;
        end
        while (m_pend != 3 && guard < 200) begin
            drive(1);
            guard++;
        end
        cmp("midrst_setup_bound", guard < 200 ? 1 : 0, 1);
        cmp("midrst_pend", int'(pend_cnt), 3);
        cmp("midrst_ptr", int'(u_on.rr_ptr), 2);
        do_reset();
        check_reset_vals();
        drive(0);
        cmp("resweep_refrC", int'(t1_refrC), 1);
        cmp("resweep_bankC", int'(t1_bankC), 0);
        cmp("resweep_pend", int'(pend_cnt), 0);
        repeat (1000) drive(0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
